// File: rtl/pcileech_ft601_tx_pkg.sv
// Shared types and framing helpers for the FT601 transmit scheduler.
// Header/trailer words let host software demultiplex the interleaved bursts.
package pcileech_ft601_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_TRL
    } tx_state_e;

    localparam logic [3:0] HDR_TAG = 4'hE;
    localparam logic [3:0] TRL_TAG = 4'hF;

    function automatic logic [31:0] make_header(input logic [3:0] id);
        return {HDR_TAG, id, 24'h00_0000};
    endfunction

    function automatic logic [31:0] make_trailer(input logic [3:0] id, input logic [15:0] count);
        return {TRL_TAG, id, 8'h00, count};
    endfunction

endpackage

// File: rtl/pcileech_rr_arb.sv
// Combinational round-robin picker: first active request at or after ptr_i, wrapping.
module pcileech_rr_arb #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IW      = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [IW-1:0]      gnt_idx_o,
    output logic               gnt_any_o
);

    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        // NOTE: every output and temporary gets a default before any branch, so no latch is inferred.
        sum       = '0;
        idx       = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_SRC)) begin
                sum = sum - (IW+1)'(NUM_SRC);
            end
            idx = sum[IW-1:0];
            if (!gnt_any_o && req_i[idx]) begin
                gnt_any_o = 1'b1;
                gnt_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/pcileech_ft601_tx_sched.sv
// Round-robin scheduler multiplexing word streams into the FT601 TX path,
// framing each grant with header/trailer and pacing on din_req_data.
module pcileech_ft601_tx_sched
    import pcileech_ft601_tx_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC*32-1:0]   src_data,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC-1:0]      src_last,
    output logic [NUM_SRC-1:0]      src_ready,
    output logic [31:0]             din,
    output logic                    din_wr_en,
    input  logic                    din_req_data
);

    localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    tx_state_e     state_q, state_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   din_q, din_d;
    logic          din_wr_en_q, din_wr_en_d;

    logic [IW-1:0] arb_idx;
    logic          arb_any;
    logic [31:0]   src_word [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_word[g] = src_data[g*32 +: 32];
    end

    pcileech_rr_arb #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_arb (
        .req_i     (src_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (arb_idx),
        .gnt_any_o (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        din_d       = din_q;
        din_wr_en_d = 1'b0;
        src_ready   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_id_d = arb_idx;
                    cnt_d    = '0;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (din_req_data) begin
                    din_d       = make_header(4'(gnt_id_q));
                    din_wr_en_d = 1'b1;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                src_ready[gnt_id_q] = din_req_data;
                if (din_req_data && src_valid[gnt_id_q]) begin
                    din_d       = src_word[gnt_id_q];
                    din_wr_en_d = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    // Truncated packets resume in a later grant; the trailer count marks the cut.
                    if (src_last[gnt_id_q] || cnt_q == LAST_CNT) begin
                        state_d = ST_TRL;
                    end
                end
            end
            ST_TRL: begin
                if (din_req_data) begin
                    din_d       = make_trailer(4'(gnt_id_q), 16'(cnt_q));
                    din_wr_en_d = 1'b1;
                    rr_ptr_d    = (gnt_id_q == IW'(NUM_SRC - 1)) ? '0 : gnt_id_q + 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_id_q    <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            din_q       <= '0;
            din_wr_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            din_q       <= din_d;
            din_wr_en_q <= din_wr_en_d;
        end
    end

    assign din       = din_q;
    assign din_wr_en = din_wr_en_q;

endmodule

// File: tb/tb_pcileech_ft601_tx_sched.sv
// Scoreboard bench for the FT601 TX scheduler: per-source word queues feed the DUT,
// expected output words are queued per scenario and popped as din_wr_en fires.
module tb_pcileech_ft601_tx_sched;

    localparam int NS = 4;
    localparam int MB = 4;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          gap;
    } word_t;

    logic              clk;
    logic              rst;
    logic [NS*32-1:0]  src_data;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_last;
    logic [NS-1:0]     src_ready;
    logic [31:0]       din;
    logic              din_wr_en;
    logic              din_req_data;

    word_t       src_q [NS][$];
    logic [31:0] exp_q [$];
    int          wr_cyc_q [$];
    int          vectors;
    int          miscompares;
    int          cyc;
    logic        req_mode;
    logic        req_prev;

    pcileech_ft601_tx_sched #(
        .NUM_SRC   (NS),
        .MAX_BURST (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .din          (din),
        .din_wr_en    (din_wr_en),
        .din_req_data (din_req_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] hdr(input int id);
        return {4'hE, 4'(id), 24'h0};
    endfunction

    function automatic logic [31:0] trl(input int id, input int n);
        return {4'hF, 4'(id), 8'h00, 16'(n)};
    endfunction

    // Source driver: retire handshaken words, then present the head of each queue.
    initial begin
        logic [NS-1:0] hs;
        word_t         w;
        src_valid    = '0;
        src_data     = '0;
        src_last     = '0;
        din_req_data = 1'b1;
        forever begin
            @(negedge clk);
            hs = src_valid & src_ready;
            @(posedge clk);
            #1;
            for (int s = 0; s < NS; s++) begin
                if (hs[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
                if (src_q[s].size() == 0) begin
                    src_valid[s] = 1'b0;
                end else begin
                    w = src_q[s].pop_front();
                    if (w.gap > 0) begin
                        src_valid[s] = 1'b0;
                        w.gap = w.gap - 1;
                    end else begin
                        src_valid[s]          = 1'b1;
                        src_data[s*32 +: 32]  = w.data;
                        src_last[s]           = w.last;
                    end
                    src_q[s].push_front(w);
                end
            end
            din_req_data = req_mode ? ~din_req_data : 1'b1;
        end
    end

    // Output monitor: every write must be expected and must follow a cycle with din_req_data high.
    initial begin
        logic [31:0] e;
        req_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (din_wr_en === 1'b1) begin
                vectors++;
                if (!req_prev) begin
                    miscompares++;
                    $display("FAIL req_lag: got wr_en after din_req_data=0 at cycle %0d, expected no write", cyc);
                end
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL din_unexpected: got %h, expected no write", din);
                end else begin
                    e = exp_q.pop_front();
                    if (din !== e) begin
                        miscompares++;
                        $display("FAIL din_word: got %h, expected %h", din, e);
                    end
                end
                wr_cyc_q.push_back(cyc);
            end
            req_prev = din_req_data;
        end
    end

    task automatic push_word(input int s, input logic [31:0] d, input logic last, input int gap);
        word_t w;
        w.data = d;
        w.last = last;
        w.gap  = gap;
        src_q[s].push_back(w);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d words outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (din_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wr_en: got %b, expected 0", din_wr_en);
        end
        vectors++;
        if (din !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_din: got %h, expected 00000000", din);
        end
        vectors++;
        if (src_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_src_ready: got %b, expected 0000", src_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        int  t_valid;
        logic seen;
        seen    = 1'b0;
        t_valid = 0;
        wr_cyc_q.delete();
        exp_q.push_back(hdr(0));
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'hD000_0000 + 32'(i));
            push_word(0, 32'hD000_0000 + 32'(i), i == 2, 0);
        end
        exp_q.push_back(trl(0, 3));
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (src_valid[0]) begin
                seen    = 1'b1;
                t_valid = cyc;
            end
        end
        wait_drain("single");
        vectors++;
        if (wr_cyc_q.size() != 5) begin
            miscompares++;
            $display("FAIL single_wr_count: got %0d, expected 5", wr_cyc_q.size());
        end else begin
            vectors++;
            if (wr_cyc_q[0] != t_valid + 2) begin
                miscompares++;
                $display("FAIL single_latency: got cycle %0d, expected %0d", wr_cyc_q[0], t_valid + 2);
            end
            vectors++;
            if (wr_cyc_q[4] != wr_cyc_q[0] + 4) begin
                miscompares++;
                $display("FAIL single_back_to_back: got last at %0d, expected %0d", wr_cyc_q[4], wr_cyc_q[0] + 4);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        exp_q.push_back(hdr(1));
        exp_q.push_back(32'hA100_0000);
        exp_q.push_back(32'hA100_0001);
        exp_q.push_back(trl(1, 2));
        exp_q.push_back(hdr(3));
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hB300_0000 + 32'(i));
        exp_q.push_back(trl(3, 3));
        exp_q.push_back(hdr(1));
        exp_q.push_back(32'hC100_0000);
        exp_q.push_back(trl(1, 1));
        push_word(1, 32'hA100_0000, 1'b0, 0);
        push_word(1, 32'hA100_0001, 1'b1, 0);
        push_word(1, 32'hC100_0000, 1'b1, 0);
        for (int i = 0; i < 3; i++) push_word(3, 32'hB300_0000 + 32'(i), i == 2, 0);
        wait_drain("round_robin");
    endtask

    task automatic test_max_burst();
        exp_q.push_back(hdr(2));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h2200_0000 + 32'(i));
        exp_q.push_back(trl(2, 4));
        exp_q.push_back(hdr(0));
        exp_q.push_back(32'h0500_0000);
        exp_q.push_back(trl(0, 1));
        exp_q.push_back(hdr(2));
        for (int i = 4; i < 8; i++) exp_q.push_back(32'h2200_0000 + 32'(i));
        exp_q.push_back(trl(2, 4));
        exp_q.push_back(hdr(2));
        for (int i = 8; i < 10; i++) exp_q.push_back(32'h2200_0000 + 32'(i));
        exp_q.push_back(trl(2, 2));
        for (int i = 0; i < 10; i++) push_word(2, 32'h2200_0000 + 32'(i), i == 9, 0);
        push_word(0, 32'h0500_0000, 1'b1, 0);
        wait_drain("max_burst");
    endtask

    task automatic test_req_toggle();
        req_mode = 1'b1;
        exp_q.push_back(hdr(0));
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h7000_0000 + 32'(i));
            push_word(0, 32'h7000_0000 + 32'(i), i == 3, 0);
        end
        exp_q.push_back(trl(0, 4));
        wait_drain("req_toggle");
        req_mode = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall();
        exp_q.push_back(hdr(1));
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h5100_0000 + 32'(i));
        exp_q.push_back(trl(1, 3));
        push_word(1, 32'h5100_0000, 1'b0, 0);
        push_word(1, 32'h5100_0001, 1'b0, 20);
        push_word(1, 32'h5100_0002, 1'b1, 0);
        for (int i = 0; i < 100 && src_q[1].size() != 2; i++) @(negedge clk);
        vectors++;
        if (src_q[1].size() != 2) begin
            miscompares++;
            $display("FAIL stall_first_word: got %0d words queued, expected 2", src_q[1].size());
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL stall_grant_held: got src_ready %b, expected 0010", src_ready);
        end
        vectors++;
        if (din_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_no_write: got wr_en %b, expected 0", din_wr_en);
        end
        wait_drain("stall");
    endtask

    task automatic test_reset_mid_burst();
        exp_q.push_back(hdr(2));
        exp_q.push_back(32'h9200_0000);
        push_word(2, 32'h9200_0000, 1'b0, 0);
        push_word(2, 32'h9200_0001, 1'b0, 30);
        push_word(2, 32'h9200_0002, 1'b1, 0);
        for (int i = 0; i < 100 && src_q[2].size() != 2; i++) @(negedge clk);
        rst = 1'b1;
        src_q[2].delete();
        @(negedge clk);
        vectors++;
        if (din_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_wr_en: got %b, expected 0", din_wr_en);
        end
        vectors++;
        if (src_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_mid_src_ready: got %b, expected 0000", src_ready);
        end
        vectors++;
        if (din !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid_din: got %h, expected 00000000", din);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_prefix: got %0d words missing, expected 0", exp_q.size());
            exp_q.delete();
        end
        rst = 1'b0;
        exp_q.push_back(hdr(3));
        exp_q.push_back(32'h3300_00AA);
        exp_q.push_back(trl(3, 1));
        push_word(3, 32'h3300_00AA, 1'b1, 0);
        wait_drain("rst_recover");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        req_mode    = 1'b0;
        rst         = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_max_burst();
        test_req_toggle();
        test_stall();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pcileech_ft601_tx_sched.md
# pcileech_ft601_tx_sched

Round-robin transmit scheduler sitting in front of the FT601 controller's TX input, sharing the single USB upstream path between up to NUM_SRC word-stream requesters (PCIe TLP readback, config/status, loopback, …). It paces writes with the controller's `din_req_data` level so the 5-deep output queue never overflows. Each grant is a burst framed by one header word and one trailer word so host software can demultiplex.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesters; 2..16.
- `MAX_BURST`, 64: data words per grant before forced re-arbitration; 1..65535.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `src_data`  in  NUM_SRC×32  per-source data word.
- `src_valid`  in  NUM_SRC  per-source word available.
- `src_last`  in  NUM_SRC  qualifies `src_data`: last word of packet.
- `src_ready`  out  NUM_SRC  combinational; word accepted when valid&ready.
- `din`  out  32  registered word to FT601 controller.
- `din_wr_en`  out  1  registered write strobe to FT601 controller.
- `din_req_data`  in  1  controller can accept words this cycle (level).

## Operation
- States: IDLE, HDR, DATA, TRL.
- IDLE: if any `src_valid`, pick first requester at or after `rr_ptr` (wrapping), latch `gnt_id`, clear `cnt` → HDR. Nothing emitted in IDLE.
- HDR: when `din_req_data`, emit header {4'hE, gnt_id[3:0], 24'h0} → DATA.
- DATA: `src_ready[gnt_id] = din_req_data`; all other `src_ready` 0. On handshake emit `src_data[gnt_id]`, `cnt++`. If `src_last` or `cnt == MAX_BURST-1` on that handshake → TRL. Source stall (valid low) holds grant indefinitely; no timeout.
- TRL: when `din_req_data`, emit trailer {4'hF, gnt_id[3:0], 8'h0, 16-bit word count (cnt zero-extended)}, set `rr_ptr = gnt_id+1` mod NUM_SRC → IDLE.
- A packet truncated by MAX_BURST continues in a later grant with a new header; `src_last` absent from that trailer is implicit (count == MAX_BURST).
- `cnt` width $clog2(MAX_BURST+1); never wraps.
- Header/trailer emission never consumes a source word.

## Timing
- Reset values: `din_wr_en`=0, `din`=0, `src_ready`=0, state IDLE, `rr_ptr`=0, `cnt`=0.
- Output latency: word emitted in cycle t (handshake or HDR/TRL with `din_req_data`) appears on `din`/`din_wr_en` at t+1; `din_wr_en` high exactly one cycle per word.
- At most one word per cycle; no emission when `din_req_data`=0. The one-cycle lag is safe: `din_req_data` only high at queue fill 2–3, so queue peaks at 5.
- Minimum grant overhead: 1 IDLE + 1 HDR + 1 TRL cycle; N-word burst at full rate = N+3 cycles.
- Simultaneous requests: rotation from `rr_ptr`; a just-served source is lowest priority next round.
- `rst` mid-burst: in-flight burst aborted, no trailer, outputs at reset values next cycle; source word in flight is dropped.

## Structure
- Package `pcileech_ft601_tx_pkg`: state enum, header/trailer nibble constants (4'hE, 4'hF).
- Sub-module `pcileech_rr_arb` (NUM_SRC requests + pointer → one-hot/index grant, combinational) used by IDLE.

## Test plan
- Reset, src0 sends 3 words (last on 3rd), `din_req_data`=1 → din sequence E0000000, D0, D1, D2, F0000003; wr_en 5 consecutive cycles starting 2 cycles after valid.
- Src1 and src3 valid together, `rr_ptr`=0 → src1 burst fully precedes src3; then src1 again valid with src3 → src3 served first.
- MAX_BURST=4, src2 streams 10 words with last on 10th → three bursts: counts 4, 4, 2, each framed E2…/F2…, other sources interleavable between.
- `din_req_data` toggles 1/0 every cycle during src0 burst → no wr_en when low-sampled, no word lost/duplicated; monitor queue model never exceeds 5.
- Source drops valid for 20 cycles mid-packet → grant held, no wr_en, trailer count correct after resume.
- `rst` asserted mid-DATA → next cycle wr_en=0, src_ready=0, state IDLE; new burst after release starts with header.
